// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit feeder, transmitter and receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Byte width of every UART data port in the design.
    localparam int UART_DATA_W = 8;

    // Launch sequencer states of the transmit feeder.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level; head entry is read combinationally from storage.
// Latency: a push is visible in level/empty one edge later; head_data follows rd_ptr directly.
// Backpressure: push ignored while full, pop ignored while empty; flush clears pointers and level.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array is deliberately left without reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue in front of the UART transmitter plus the start/done launch sequencer.
// Latency: byte written at edge N raises o_tx_start after N+1; next byte relaunches one edge after done rises.
// Backpressure: o_wr_ready drops when full (offers then set sticky o_overflow); o_tx_start held until done falls.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    input  logic                     i_wr_valid,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_wr_ready,
    input  logic                     i_flush,
    input  logic                     i_clr_ovf,
    input  logic                     i_tx_done,
    output logic                     o_tx_start,
    output logic [DATA_W-1:0]        o_tx_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow
);
    feeder_state_t     state;
    logic              wr_accept;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    // Ready comes from the registered level only, so a same-cycle pop never opens room.
    assign o_wr_ready = ~o_full;
    assign wr_accept  = i_wr_valid && o_wr_ready && !i_flush;
    // The head byte leaves the queue on the edge where the transmitter shows it took the byte.
    assign pop        = (state == LAUNCH) && !i_tx_done && !i_flush;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_areset),
        .push      (wr_accept),
        .push_data (i_wr_data),
        .pop       (pop),
        .flush     (i_flush),
        .head_data (head_data),
        .level     (o_level),
        .empty     (o_empty),
        .full      (o_full)
    );

    // Sticky overflow: an offer against a full queue sets it, and setting beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_overflow <= 1'b0;
        end else if (i_wr_valid && o_full && !i_flush) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

    // Launch sequencer: present a byte, hold it until the transmitter goes busy, then wait for idle.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state      <= IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A flushed queue must not launch the stale head entry.
                    if (!o_empty && i_tx_done && !i_flush) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= head_data;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!i_tx_done) begin
                        // Transmitter took the byte (or, during a flush, one is in flight anyway).
                        o_tx_start <= 1'b0;
                        state      <= BUSY;
                    end else if (i_flush) begin
                        o_tx_start <= 1'b0;
                        state      <= IDLE;
                    end
                end
                BUSY: begin
                    // Relaunch straight from BUSY so queued bytes go out one cycle after done rises;
                    // a flush keeps us here until the in-flight frame has been seen to finish.
                    if (i_tx_done && !i_flush) begin
                        if (!o_empty) begin
                            o_tx_start <= 1'b1;
                            o_tx_data  <= head_data;
                            state      <= LAUNCH;
                        end else begin
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    o_tx_start <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural transmitter and serial-line decoder.
// Latency: n/a.
// Backpressure: the transmitter model can refuse, be overridden manually, or run at 115200 baud.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DATA_W = UART_DATA_W;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              wr_ready;
    logic              flush    = 1'b0;
    logic              clr_ovf  = 1'b0;
    logic              tx_done;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [LW-1:0]     level;
    logic              empty;
    logic              full;
    logic              overflow;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk      (clk),
        .i_areset   (rst),
        .i_wr_valid (wr_valid),
        .i_wr_data  (wr_data),
        .o_wr_ready (wr_ready),
        .i_flush    (flush),
        .i_clr_ovf  (clr_ovf),
        .i_tx_done  (tx_done),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_level    (level),
        .o_empty    (empty),
        .o_full     (full),
        .o_overflow (overflow)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: bytes expected at the transmitter handshake and on the serial line.
    logic [7:0] exp_q[$];
    logic [7:0] ser_exp[$];
    logic [7:0] t6_bytes [3] = '{8'h11, 8'h22, 8'h33};

    // Transmitter model: 10-bit frame, cpb clocks per bit, done low while a frame is in flight.
    int         cpb      = 4;
    logic       refuse   = 1'b0;
    logic       manual   = 1'b0;
    logic       man_done = 1'b1;
    logic       m_done   = 1'b1;
    logic [9:0] m_sh     = '1;
    logic [3:0] m_bits   = '0;
    int         m_cnt    = 0;
    logic       ser      = 1'b1;
    logic       acc_pulse = 1'b0;
    logic [7:0] acc_data  = '0;

    assign tx_done = manual ? man_done : m_done;

    always @(posedge clk) begin
        acc_pulse <= 1'b0;
        if (m_done) begin
            if (tx_start && !refuse && !manual) begin
                m_done    <= 1'b0;
                m_sh      <= {1'b1, tx_data, 1'b0};
                m_bits    <= '0;
                m_cnt     <= 0;
                ser       <= 1'b0;
                acc_pulse <= 1'b1;
                acc_data  <= tx_data;
            end
        end else if (m_cnt == cpb - 1) begin
            m_cnt <= 0;
            if (m_bits == 4'd9) begin
                m_done <= 1'b1;
                ser    <= 1'b1;
            end else begin
                m_bits <= m_bits + 4'd1;
                ser    <= m_sh[m_bits + 4'd1];
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Handshake scoreboard: each accepted launch must carry the oldest queued byte.
    always @(negedge clk) begin
        if (acc_pulse) begin
            check("launch_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("launch_data", 32'(acc_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Serial decoder: samples mid-bit and checks bytes against the serial scoreboard when enabled.
    logic ser_chk = 1'b0;
    always begin
        logic [7:0] b;
        @(negedge ser);
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = ser;
        end
        repeat (cpb) @(negedge clk);
        if (ser_chk) begin
            check("ser_stop", 32'(ser), 32'd1);
            check("ser_pending", 32'(ser_exp.size() != 0), 32'd1);
            if (ser_exp.size() != 0) begin
                check("ser_byte", 32'(b), 32'(ser_exp.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accept);
        wr_valid = 1'b1;
        wr_data  = d;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input logic val, input int bound, input string tag);
        int n = 0;
        while (tx_done !== val && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_done), 32'(val));
    endtask

    task automatic wait_start(input logic val, input int bound, input string tag);
        int n = 0;
        while (tx_start !== val && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_start), 32'(val));
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_start"},    32'(tx_start), 32'd0);
        check({pfx, "_data"},     32'(tx_data),  32'd0);
        check({pfx, "_level"},    32'(level),    32'd0);
        check({pfx, "_empty"},    32'(empty),    32'd1);
        check({pfx, "_full"},     32'(full),     32'd0);
        check({pfx, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check({pfx, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        // Reset state.
        tick(3);
        check_reset_values("rst");
        rst = 1'b0;
        tick(2);

        // Single byte with the transmitter idle.
        write_byte(8'hA5, 1'b1);
        check("t1_level_n", 32'(level), 32'd1);
        check("t1_start_n", 32'(tx_start), 32'd0);
        tick(1);
        check("t1_start_n1", 32'(tx_start), 32'd1);
        check("t1_data_n1", 32'(tx_data), 32'hA5);
        tick(1);
        check("t1_level_n2", 32'(level), 32'd1);
        check("t1_start_n2", 32'(tx_start), 32'd1);
        tick(1);
        check("t1_start_n3", 32'(tx_start), 32'd0);
        check("t1_level_n3", 32'(level), 32'd0);
        check("t1_empty_n3", 32'(empty), 32'd1);
        wait_done(1'b1, 200, "t1_frame_done");
        tick(2);

        // Fill to full while the transmitter refuses, then overflow handling.
        refuse = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        check("t2_full", 32'(full), 32'd1);
        check("t2_wr_ready", 32'(wr_ready), 32'd0);
        check("t2_level", 32'(level), 32'd16);
        check("t2_ovf_clear", 32'(overflow), 32'd0);
        write_byte(8'h10, 1'b0);
        check("t2_ovf_set", 32'(overflow), 32'd1);
        check("t2_level_ovf", 32'(level), 32'd16);
        wr_valid = 1'b1;
        wr_data  = 8'h10;
        clr_ovf  = 1'b1;
        tick(1);
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
        check("t2_ovf_set_wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("t2_ovf_cleared", 32'(overflow), 32'd0);

        // Launch held for 20 refused cycles, then a single pop on accept.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t3_hold_start", 32'(tx_start), 32'd1);
            check("t3_hold_data", 32'(tx_data), 32'h00);
        end
        refuse = 1'b0;
        tick(1);
        refuse = 1'b1;
        check("t3_accept_level", 32'(level), 32'd16);
        check("t3_accept_start", 32'(tx_start), 32'd1);
        tick(1);
        check("t3_pop_level", 32'(level), 32'd15);
        check("t3_pop_start", 32'(tx_start), 32'd0);
        check("t3_pop_wr_ready", 32'(wr_ready), 32'd1);

        // Flush while LAUNCH is refused: start drops, nothing sent, queue empty.
        wait_start(1'b1, 200, "t4_relaunch");
        check("t4_relaunch_data", 32'(tx_data), 32'h01);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        check("t4_start", 32'(tx_start), 32'd0);
        check("t4_level", 32'(level), 32'd0);
        check("t4_empty", 32'(empty), 32'd1);
        tick(3);
        check("t4_no_start", 32'(tx_start), 32'd0);
        refuse = 1'b0;

        // Flush while BUSY: in-flight frame completes, queued bytes are gone.
        ser_chk = 1'b1;
        ser_exp.push_back(8'h40);
        write_byte(8'h40, 1'b1);
        write_byte(8'h41, 1'b1);
        write_byte(8'h42, 1'b1);
        wait_done(1'b0, 20, "t5_accept");
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        check("t5_level", 32'(level), 32'd0);
        check("t5_start", 32'(tx_start), 32'd0);
        wait_done(1'b1, 200, "t5_frame_done");
        tick(4);
        check("t5_nothing_after", 32'(tx_start), 32'd0);
        check("t5_serial_drained", 32'(ser_exp.size()), 32'd0);
        ser_chk = 1'b0;

        // Three bytes at 115200 baud from 100 MHz: in-order frames, one-cycle relaunch gap.
        cpb     = 868;
        ser_chk = 1'b1;
        for (int k = 0; k < 3; k++) ser_exp.push_back(t6_bytes[k]);
        for (int k = 0; k < 3; k++) write_byte(t6_bytes[k], 1'b1);
        for (int k = 0; k < 2; k++) begin
            wait_done(1'b0, 3000, "t6_accept");
            wait_done(1'b1, 10000, "t6_done_rise");
            check("t6_gap_low", 32'(tx_start), 32'd0);
            tick(1);
            check("t6_gap_high", 32'(tx_start), 32'd1);
            check("t6_next_data", 32'(tx_data), 32'(t6_bytes[k + 1]));
        end
        wait_done(1'b0, 3000, "t6_accept_last");
        wait_done(1'b1, 10000, "t6_done_last");
        tick(2);
        check("t6_serial_drained", 32'(ser_exp.size()), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        ser_chk = 1'b0;
        cpb     = 4;

        // Asynchronous reset mid-frame while the transmitter reports busy.
        manual   = 1'b1;
        man_done = 1'b1;
        write_byte(8'h77, 1'b0);
        tick(1);
        check("t7_launch", 32'(tx_start), 32'd1);
        man_done = 1'b0;
        tick(2);
        write_byte(8'h78, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_values("t7_async");
        tick(1);
        rst = 1'b0;
        tick(1);
        write_byte(8'h79, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t7_hold_off", 32'(tx_start), 32'd0);
        end
        man_done = 1'b1;
        tick(1);
        check("t7_start_after_done", 32'(tx_start), 32'd1);
        check("t7_data", 32'(tx_data), 32'h79);
        exp_q.push_back(8'h79);
        manual = 1'b0;
        wait_done(1'b0, 20, "t7_accept");
        wait_done(1'b1, 200, "t7_frame_done");
        tick(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
